// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART byte transmitter between NUM_REQ sources,
// sequences its start/busy handshake and generates the baud tick. Optional: UART_TX_SCHED_LOCK_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int CLOCKS_PER_BIT = 868,
  parameter int BUSY_TIMEOUT   = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       baud_tick,
  output logic                       tx_timeout
);

  localparam int IDW    = $clog2(NUM_REQ);
  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int TO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDW-1:0]    PTR_RST   = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDW-1:0]      rr_ptr;
  logic [TO_W-1:0]     wait_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  sel_onehot;
  logic [IDW-1:0]      sel_idx;
  logic [7:0]          sel_byte;
  logic                sel_found;
  logic                accept;
  logic                timeout_nxt;
  logic                wait_clr;
  logic                wait_inc;

`ifdef UART_TX_SCHED_LOCK_EN
  logic                lock_active;
  logic [IDW-1:0]      lock_id;

  // While locked, only the owning requester may compete.
  always_comb begin
    eligible = req_valid;
    if (lock_active) begin
      eligible = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (IDW'(j) == lock_id) eligible[j] = req_valid[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_id     <= '0;
    end else if (timeout_nxt) begin
      lock_active <= 1'b0;
    end else if (accept) begin
      lock_active <= ~|(req_last & sel_onehot);
      lock_id     <= sel_idx;
    end
  end
`else
  assign eligible = req_valid;
`endif

  // Search starts just after the last grant, so that requester drops to lowest priority.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_byte   = '0;
    sel_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!sel_found && eligible[j] && (j == (int'(rr_ptr) + k) % NUM_REQ)) begin
          sel_found     = 1'b1;
          sel_idx       = IDW'(j);
          sel_byte      = req_data[8*j +: 8];
          sel_onehot[j] = 1'b1;
        end
      end
    end
  end

  assign req_ready = (state == IDLE && reset_n && !tx_busy) ? sel_onehot : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    tx_start    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        wait_clr  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_RST;
      wait_cnt   <= '0;
      tx_timeout <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
    end else begin
      state      <= state_nxt;
      tx_timeout <= timeout_nxt;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (accept) begin
        tx_data  <= sel_byte;
        grant_id <= sel_idx;
        rr_ptr   <= sel_idx;
      end
    end
  end

  // Cleared on the accepting edge so the count reads 0 in the LAUNCH cycle and the
  // first tick lands one full bit period after tx_start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      baud_cnt  <= '0;
      baud_tick <= 1'b0;
    end else if (accept) begin
      baud_cnt  <= '0;
      baud_tick <= 1'b0;
    end else begin
      baud_tick <= (baud_cnt == BAUD_LAST);
      baud_cnt  <= (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: randomized traffic against a round-robin reference
// model, with a behavioural transmitter that answers tx_start with a tx_busy frame.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;
  localparam int BTO     = 16;

  logic                 clock;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 baud_tick;
  logic                 tx_timeout;
`ifdef UART_TX_SCHED_LOCK_EN
  logic [NUM_REQ-1:0]   req_last;
`endif

  int checks   = 0;
  int failures = 0;
  int busy_delay = 2;
  int busy_len   = 20;
  bit busy_drop  = 1'b0;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .CLOCKS_PER_BIT(CPB), .BUSY_TIMEOUT(BTO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_last(req_last),
`endif
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .baud_tick(baud_tick), .tx_timeout(tx_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Transmitter model: busy rises busy_delay cycles after tx_start and holds busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (tx_start === 1'b1 && !busy_drop) begin
        repeat (busy_delay) @(posedge clock);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clock);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] m);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (m[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic step_cycle();
    @(posedge clock);
    #3;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_cycle();
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (6) step_cycle();
    for (int i = 0; i < 100 && tx_busy; i++) step_cycle();
    repeat (20) step_cycle();
  endtask

  task automatic do_reset();
    drain();
    busy_drop = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    req_last = '1;
`endif
    reset_n = 1'b0;
    repeat (2) step_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_data  = $urandom;
    repeat (3) step_cycle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", tx_timeout); end
    checks++; if (baud_tick !== 1'b0) begin failures++; $display("FAIL reset_baud: got %b expected 0", baud_tick); end
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_priority: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int t;
    int extra_starts;
    busy_delay = 2; busy_len = 20; busy_drop = 1'b0;
    extra_starts = 0;
    req_data = $urandom;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    step_cycle();
    req_valid = '0;
    #1;
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", tx_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready); end
    step_cycle();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b expected 0", tx_start); end
    t = 0;
    while (!tx_busy && t < 10) begin step_cycle(); t++; end
    t = 0;
    while (tx_busy && t < 40) begin
      step_cycle(); t++;
      if (tx_start === 1'b1) extra_starts++;
    end
    checks++; if (t >= 40 || tx_busy) begin failures++; $display("FAIL single_busy_end: busy still %b after %0d cycles, expected fall", tx_busy, t); end
    checks++; if (extra_starts != 0) begin failures++; $display("FAIL single_restart: got %0d extra tx_start expected 0", extra_starts); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_hold: got %h expected a5", tx_data); end
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_wait_done: got %b expected 0000", req_ready); end
    step_cycle();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_idle_return: got %b expected 0010", req_ready); end
    req_valid = '0;
    drain();
  endtask

  task automatic test_round_robin();
    int ptr;
    int exp_id;
    logic [7:0] exp_byte;
    logic [NUM_REQ-1:0] mask;
    logic [8*NUM_REQ-1:0] data;
    bit seen;
    do_reset();
    busy_delay = 2; busy_len = 5;
    mask = '1;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = mask;
    req_data  = data;
    ptr = NUM_REQ - 1;
    for (int n = 0; n < 17; n++) begin
      if (n < 5) begin
        exp_id   = n % NUM_REQ;
        exp_byte = 8'h10 + 8'(n % NUM_REQ);
      end else begin
        exp_id   = rr_pick(ptr, mask);
        exp_byte = data[8*exp_id +: 8];
      end
      wait_start(200, seen);
      checks++; if (!seen) begin failures++; $display("FAIL rr_start_%0d: no tx_start within 200 cycles, expected one", n); end
      checks++; if (grant_id !== 2'(exp_id)) begin failures++; $display("FAIL rr_grant_%0d: got %0d expected %0d", n, grant_id, exp_id); end
      checks++; if (tx_data !== exp_byte) begin failures++; $display("FAIL rr_data_%0d: got %h expected %h", n, tx_data, exp_byte); end
      ptr = exp_id;
      if (n + 1 >= 5) begin
        mask = NUM_REQ'($urandom_range(1, 15));
        for (int i = 0; i < NUM_REQ; i++) data[8*i +: 8] = 8'($urandom);
        req_valid  = mask;
        req_data   = data;
        busy_delay = $urandom_range(1, 4);
        busy_len   = $urandom_range(1, 12);
        busy_drop  = ($urandom_range(0, 5) == 0);
      end
    end
    drain();
    busy_drop = 1'b0;
  endtask

  task automatic test_timeout();
    bit seen;
    int early;
    logic [7:0] byte1;
    do_reset();
    busy_drop = 1'b1;
    req_data = $urandom;
    byte1 = req_data[15:8];
    req_valid = 4'b0011;
    wait_start(10, seen);
    checks++; if (!seen) begin failures++; $display("FAIL to_start: no tx_start within 10 cycles, expected one"); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL to_first_grant: got %0d expected 0", grant_id); end
    early = 0;
    for (int k = 1; k <= BTO; k++) begin
      step_cycle();
      if (tx_timeout !== 1'b0) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL to_early: got %0d early pulses expected 0", early); end
    step_cycle();
    checks++; if (tx_timeout !== 1'b1) begin failures++; $display("FAIL to_pulse: got %b expected 1", tx_timeout); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_idle_next: got %b expected 0010", req_ready); end
    busy_drop = 1'b0;
    step_cycle();
    req_valid = '0;
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL to_single_pulse: got %b expected 0", tx_timeout); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL to_next_start: got %b expected 1", tx_start); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL to_next_grant: got %0d expected 1", grant_id); end
    checks++; if (tx_data !== byte1) begin failures++; $display("FAIL to_next_data: got %h expected %h", tx_data, byte1); end
    drain();
  endtask

  task automatic test_baud();
    int ticks[$];
    int bad_gap;
    bit seen;
    bit exp_tick;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step_cycle();
      if (baud_tick === 1'b1) ticks.push_back(i);
    end
    bad_gap = 0;
    for (int i = 1; i < ticks.size(); i++) if (ticks[i] - ticks[i-1] != CPB) bad_gap++;
    checks++; if (ticks.size() != 24 / CPB) begin failures++; $display("FAIL baud_idle_count: got %0d ticks expected %0d", ticks.size(), 24 / CPB); end
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL baud_idle_period: got %0d bad gaps expected 0", bad_gap); end
    repeat ($urandom_range(0, 7)) step_cycle();
    busy_delay = 2; busy_len = 3;
    req_data = $urandom;
    req_valid = 4'b0001;
    wait_start(10, seen);
    req_valid = '0;
    checks++; if (!seen) begin failures++; $display("FAIL baud_start: no tx_start within 10 cycles, expected one"); end
    for (int k = 0; k <= 2 * CPB; k++) begin
      if (k > 0) step_cycle();
      exp_tick = (k == CPB) || (k == 2 * CPB);
      checks++; if (baud_tick !== exp_tick) begin failures++; $display("FAIL baud_restart_%0d: got %b expected %b", k, baud_tick, exp_tick); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen;
    int t;
    int starts;
    logic [7:0] byte0;
    do_reset();
    busy_delay = 2; busy_len = 30;
    req_data = $urandom;
    req_data[23:16] = 8'hC3;
    byte0 = req_data[7:0];
    req_valid = 4'b0100;
    wait_start(10, seen);
    req_valid = 4'b0101;
    checks++; if (!seen || grant_id !== 2'd2) begin failures++; $display("FAIL mid_first_grant: got %0d (start %b) expected 2", grant_id, seen); end
    repeat (6) step_cycle();
    reset_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
    step_cycle();
    reset_n = 1'b1;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h expected 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_grant: got %0d expected 0", grant_id); end
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL mid_timeout: got %b expected 0", tx_timeout); end
    checks++; if (baud_tick !== 1'b0) begin failures++; $display("FAIL mid_baud: got %b expected 0", baud_tick); end
    starts = 0;
    t = 0;
    while (tx_busy && t < 60) begin
      step_cycle(); t++;
      if (tx_start === 1'b1) starts++;
    end
    checks++; if (starts != 0 || tx_busy) begin failures++; $display("FAIL mid_no_restart: got %0d starts busy=%b expected 0 starts", starts, tx_busy); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_priority: got %b expected 0001", req_ready); end
    step_cycle();
    req_valid = '0;
    checks++; if (tx_start !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL mid_after_grant: got start=%b grant=%0d expected start=1 grant=0", tx_start, grant_id); end
    checks++; if (tx_data !== byte0) begin failures++; $display("FAIL mid_after_data: got %h expected %h", tx_data, byte0); end
    drain();
  endtask

`ifdef UART_TX_SCHED_LOCK_EN
  task automatic test_lock();
    bit seen;
    int exp_id;
    logic [7:0] exp_byte;
    do_reset();
    busy_delay = 1; busy_len = 4;
    req_data = $urandom;
    req_last = 4'b1011;
    req_valid = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      exp_id   = (n < 3) ? 2 : 0;
      exp_byte = req_data[8*exp_id +: 8];
      wait_start(100, seen);
      checks++; if (!seen) begin failures++; $display("FAIL lock_start_%0d: no tx_start within 100 cycles, expected one", n); end
      checks++; if (grant_id !== 2'(exp_id)) begin failures++; $display("FAIL lock_grant_%0d: got %0d expected %0d", n, grant_id, exp_id); end
      checks++; if (tx_data !== exp_byte) begin failures++; $display("FAIL lock_data_%0d: got %h expected %h", n, tx_data, exp_byte); end
      req_data[23:16] = 8'($urandom);
      if (n == 0) req_valid = 4'b0101;
      if (n == 1) req_last = 4'b1111;
      if (n == 2) req_valid = 4'b0001;
    end
    drain();
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
`ifdef UART_TX_SCHED_LOCK_EN
    req_last  = '1;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_baud();
    test_reset_mid();
`ifdef UART_TX_SCHED_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART byte transmitter between NUM_REQ requesters using round-robin arbitration.
- Sequences the transmitter through a start/busy handshake.
- Generates the baud tick that the transmitter shifts on.
- Sits between the application byte sources and the UART transmit datapath, mirroring the receive side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLOCKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200)
BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before abandoning the byte

Ports:
clock  input  1  system clock, all logic on its rising edge
reset_n  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester byte-available flag
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot accept; a transfer occurs on an edge where req_valid[i] & req_ready[i]
tx_start  output  1  one-cycle pulse that launches the transmitter
tx_data  output  8  byte to transmit; stable from tx_start until return to IDLE
tx_busy  input  1  transmitter frame in progress
grant_id  output  clog2(NUM_REQ)  index of the requester that owns the current byte
baud_tick  output  1  one-cycle pulse every CLOCKS_PER_BIT cycles
tx_timeout  output  1  one-cycle pulse when tx_busy fails to rise

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE; tx_start=0, tx_data=0, grant_id=0, tx_timeout=0, baud_tick=0.
  - Baud counter=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to 0 while reset_n is low.
  - Reset mid-frame abandons the byte. tx_start is never re-issued for it.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first valid requester searched from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - It is all-zero if no valid requester or if tx_busy=1.
  - On the accepting edge: tx_data<=selected byte, grant_id<=index, rr_ptr<=index, state->LAUNCH.
- LAUNCH:
  - tx_start=1 for exactly this cycle. tx_start rises the cycle after acceptance (latency 1).
  - Baud counter cleared, so the first baud_tick occurs CLOCKS_PER_BIT cycles after the tx_start cycle.
  - state->WAIT_BUSY, timeout counter=0.
- WAIT_BUSY:
  - If tx_busy=1, state->WAIT_DONE.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT-1 without busy, tx_timeout pulses for 1 cycle and state->IDLE; the byte is dropped.
- WAIT_DONE: when tx_busy=0, state->IDLE. The next accept can occur in that IDLE cycle.
- Back-to-back bytes: minimum spacing between tx_start pulses is 3 cycles plus the busy time.
- Baud counter:
  - Counts 0..CLOCKS_PER_BIT-1 and wraps.
  - baud_tick is a registered pulse when the count equals CLOCKS_PER_BIT-1.
  - The counter free-runs in every state; LAUNCH clear has priority over wrap.
- Fairness: a requester just granted has lowest priority next round. With all requesters valid, grant order is 0,1,2,3,0,…
- req_valid dropping before acceptance is legal; no transfer occurs.
- tx_data and grant_id hold their value outside LAUNCH/WAIT states.

Optional Feature:
UART_TX_SCHED_LOCK_EN
- Defined:
  - Adds input req_last [NUM_REQ].
  - Accepting a byte with req_last[i]=0 locks arbitration to requester i. In IDLE only i may receive req_ready; others wait even if valid.
  - The lock releases after accepting a byte with req_last[i]=1, a tx_timeout, or reset.
  - rr_ptr updates normally.
- Undefined: port absent; every byte is arbitrated independently.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5, tx_busy rises 2 cycles after tx_start and is held for 20 cycles -> req_ready=0001 for 1 cycle, tx_start 1 cycle later, tx_data=A5, grant_id=0, return to IDLE the cycle after tx_busy falls.
- All four valid with bytes 10,11,12,13 and a busy model -> tx_data sequence 10,11,12,13,10; grant_id 0,1,2,3,0.
- tx_busy held 0 after tx_start -> tx_timeout pulses once exactly 16 cycles after the WAIT_BUSY entry, state IDLE, next requester served.
- CLOCKS_PER_BIT=4, idle -> baud_tick every 4 cycles. On tx_start, the counter restarts and the first tick comes 4 cycles after the tx_start cycle.
- reset_n low for 1 cycle during WAIT_DONE -> all outputs 0 next cycle, no repeated tx_start; requester 0 has priority afterwards.
- LOCK_EN: requester 2 sends 3 bytes with last=0,0,1 while requester 0 is continuously valid -> the three bytes from requester 2 go consecutively, then requester 0 is granted.
